// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state type and default sizing.
package hilo_muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_STEPS = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef logic [1:0] md_state_t;

    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_MUL  = 2'd1;
    localparam md_state_t ST_DIV  = 2'd2;

    // MULT and DIV interpret operands as two's complement.
    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_md_step.sv
// One radix-2 iteration on operand magnitudes: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, m} : '0);
        rem    = {hi_in, lo_in[WIDTH-1]};
        diff   = rem - {1'b0, m};
        hi_out = '0;
        lo_out = '0;
        if (is_div) begin
            // Partial remainder stays below the divisor, so a clear top bit means rem >= m.
            if (!diff[WIDTH]) begin
                hi_out = diff[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = rem[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_out = sum[WIDTH:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers,
// mthi/mtlo moves and a one-cycle done pulse.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int STEPS = MD_STEPS
) (
    input  logic             MD_CLK,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hodata,
    output logic [WIDTH-1:0] lodata
);

    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    md_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mq_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;

    logic               a_neg;
    logic               b_neg;
    logic               a_in_neg;
    logic [WIDTH-1:0]   a_in_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   hi_step;
    logic [WIDTH-1:0]   lo_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               last_step;

    assign busy   = (state_reg == ST_MUL) || (state_reg == ST_DIV);
    assign done   = done_reg;
    assign hodata = hi_reg;
    assign lodata = lo_reg;

    always_comb begin
        a_in_neg  = md_is_signed(op) && a[WIDTH-1];
        a_in_mag  = a_in_neg ? -a : a;
        a_neg     = md_is_signed(op_reg) && a_reg[WIDTH-1];
        b_neg     = md_is_signed(op_reg) && b_reg[WIDTH-1];
        b_mag     = b_neg ? -b_reg : b_reg;
        last_step = (cnt_reg == CNT_W'(STEPS - 1));
    end

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div (state_reg == ST_DIV),
        .hi_in  (acc_reg),
        .lo_in  (mq_reg),
        .m      (b_mag),
        .hi_out (hi_step),
        .lo_out (lo_step)
    );

    // Signs are applied only to the final step's magnitudes; remainder follows the dividend.
    always_comb begin
        prod     = {hi_step, lo_step};
        prod_fix = (a_neg ^ b_neg) ? -prod : prod;
        quot_fix = (a_neg ^ b_neg) ? -lo_step : lo_step;
        rem_fix  = a_neg ? -hi_step : hi_step;
    end

    always_ff @(posedge MD_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            mq_reg    <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        op_reg    <= op;
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                        mq_reg    <= a_in_mag;
                        state_reg <= op[1] ? ST_DIV : ST_MUL;
                    end else begin
                        if (mthi) hi_reg <= wdata;
                        if (mtlo) lo_reg <= wdata;
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_reg <= hi_step;
                    mq_reg  <= lo_step;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_step) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                        if (state_reg == ST_DIV) begin
                            // Divide by zero returns all-ones quotient and the raw dividend.
                            if (b_reg == '0) begin
                                hi_reg <= a_reg;
                                lo_reg <= '1;
                            end else begin
                                hi_reg <= rem_fix;
                                lo_reg <= quot_fix;
                            end
                        end else begin
                            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_reg <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomised and directed checks of hilo_muldiv against a plain-arithmetic
// reference model of MIPS MULT/MULTU/DIV/DIVU and HI/LO moves.
module tb_hilo_muldiv;

    logic        MD_CLK = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hodata;
    logic [31:0] lodata;

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    hilo_muldiv #(.WIDTH(32), .STEPS(32)) dut (
        .MD_CLK  (MD_CLK),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hodata  (hodata),
        .lodata  (lodata)
    );

    always #5 MD_CLK = ~MD_CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // MIPS semantics from integer arithmetic; SV / and % truncate toward zero.
    function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint      sx;
        longint      sy;
        longint      r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        hi = '0;
        lo = '0;
        case (o)
            2'b00: begin r = sx * sy; u = r; hi = u[63:32]; lo = u[31:0]; end
            2'b01: begin u = {32'd0, x} * {32'd0, y}; hi = u[63:32]; lo = u[31:0]; end
            2'b10: begin
                if (y == 0) begin hi = x; lo = 32'hFFFF_FFFF; end
                else begin
                    r = sx / sy; u = r; lo = u[31:0];
                    r = sx % sy; u = r; hi = u[31:0];
                end
            end
            default: begin
                if (y == 0) begin hi = x; lo = 32'hFFFF_FFFF; end
                else begin lo = x / y; hi = x % y; end
            end
        endcase
    endfunction

    // Drives start immediately (caller ensures IDLE or the done cycle), then waits for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit hazard);
        logic [31:0] rh;
        logic [31:0] rl;
        int          edges;
        ref_op(o, x, y, rh, rl);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge MD_CLK); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        edges = 0;
        while (!done && edges < 64) begin
            if (hazard && edges == 5) begin
                start = 1'b1; op = 2'b10; mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
            end
            @(posedge MD_CLK); #1;
            edges++;
            if (hazard && edges == 6) begin start = 1'b0; mthi = 1'b0; mtlo = 1'b0; end
            if (edges == 16) begin
                check("hi_hold", 64'(hodata), 64'(exp_hi));
                check("lo_hold", 64'(lodata), 64'(exp_lo));
            end
        end
        // done becomes visible after the 32nd edge following the start edge (33 edges inclusive).
        check("latency", 64'(edges), 64'd32);
        check("hi", 64'(hodata), 64'(rh));
        check("lo", 64'(lodata), 64'(rl));
        check("busy_at_done", 64'(busy), 64'd0);
        exp_hi = rh;
        exp_lo = rl;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h) edges=%0d",
                 o, x, y, hodata, lodata, rh, rl, edges);
    endtask

    task automatic check_done_fall();
        @(posedge MD_CLK); #1;
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        int          done_seen;
        logic [31:0] rb;
        reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(posedge MD_CLK);
        @(negedge MD_CLK);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hodata), 64'd0);
        check("rst_lo", 64'(lodata), 64'd0);
        reset_n = 1'b1;

        // Directed cases.
        @(negedge MD_CLK); run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 0);          check_done_fall();
        @(negedge MD_CLK); run_op(2'b11, 32'd100, 32'd7, 0);                check_done_fall();
        @(negedge MD_CLK); run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);          check_done_fall();
        @(negedge MD_CLK); run_op(2'b10, 32'h1234_5678, 32'd0, 0);          check_done_fall();
        @(negedge MD_CLK); run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);  check_done_fall();

        // Hazard: ignored start/moves while busy, then a start in the done cycle.
        @(negedge MD_CLK);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op(2'b00, 32'h0001_0000, 32'hFFFF_0000, 0);
        check_done_fall();
        check("no_extra_op", 64'(busy), 64'd0);

        // Randomised ops, with divisor corner values mixed in.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            @(negedge MD_CLK);
            run_op(2'($urandom), $urandom, rb, 0);
            check_done_fall();
        end

        // mthi/mtlo together, then individually.
        @(negedge MD_CLK); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge MD_CLK); #1; mthi = 1'b0; mtlo = 1'b0;
        check("mthi_both", 64'(hodata), 64'hA5A5_A5A5);
        check("mtlo_both", 64'(lodata), 64'hA5A5_A5A5);
        exp_hi = 32'hA5A5_A5A5; exp_lo = 32'hA5A5_A5A5;
        $display("mthi+mtlo wdata=a5a5a5a5 -> hi=%h lo=%h", hodata, lodata);
        @(negedge MD_CLK); mthi = 1'b1; wdata = $urandom; exp_hi = wdata;
        @(posedge MD_CLK); #1; mthi = 1'b0;
        check("mthi_only_hi", 64'(hodata), 64'(exp_hi));
        check("mthi_only_lo", 64'(lodata), 64'(exp_lo));
        $display("mthi wdata=%h -> hi=%h lo=%h", exp_hi, hodata, lodata);

        // start beats moves in the same IDLE cycle.
        @(negedge MD_CLK); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_F00D;
        run_op(2'b11, 32'd1000, 32'd10, 0);
        mthi = 1'b0; mtlo = 1'b0;
        check_done_fall();
        @(negedge MD_CLK); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge MD_CLK); #1; mthi = 1'b0; mtlo = 1'b0;
        exp_hi = 32'hA5A5_A5A5; exp_lo = 32'hA5A5_A5A5;

        // Reset mid-DIV at step 10.
        @(negedge MD_CLK); start = 1'b1; op = 2'b10; a = 32'h7654_3210; b = 32'd3;
        @(posedge MD_CLK); #1; start = 1'b0;
        repeat (10) @(posedge MD_CLK);
        #1; reset_n = 1'b0; #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hodata), 64'd0);
        check("abort_lo", 64'(lodata), 64'd0);
        repeat (2) @(posedge MD_CLK);
        @(negedge MD_CLK); reset_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge MD_CLK); #1;
            if (done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_hi_after", 64'(hodata), 64'd0);
        $display("reset mid-DIV -> busy=%0b hi=%h lo=%h done_seen=%0d", busy, hodata, lodata, done_seen);
        exp_hi = '0; exp_lo = '0;

        // Start accepted on the first edge after reset release.
        @(negedge MD_CLK); reset_n = 1'b0;
        @(negedge MD_CLK); reset_n = 1'b1;
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        check_done_fall();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
